gpr_wb_arbiter: RTL and testbench

// Writeback stage feeding the GPR register file write port (wr[3:0]/wa/i).
// Two result sources each push into a private FIFO:
//   - src0: ALU/FPU results.
//   - src1: load data.
// A round-robin arbiter drains one entry per cycle onto a registered write port.

---
 rtl/gpr_wb_arbiter_if.sv | 47 ++++
 rtl/gpr_wb_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_wb_arbiter_if.sv
// Bus bundle for the GPR writeback arbiter. It carries the two result-source
// push ports, the registered regfile write port, the scoreboard query and busy.
interface gpr_wb_arbiter_if #(
   parameter int TID_W = 4
);
   logic             s0_valid;
   logic             s0_ready;
   logic [TID_W-1:0] s0_tid;
   logic [5:0]       s0_reg;
   logic [3:0]       s0_be;
   logic [31:0]      s0_data;

   logic             s1_valid;
   logic             s1_ready;
   logic [TID_W-1:0] s1_tid;
   logic [5:0]       s1_reg;
   logic [3:0]       s1_be;
   logic [31:0]      s1_data;

   logic [3:0]       wr;
   logic [TID_W+5:0] wa;
   logic [31:0]      wd;

   logic [TID_W+5:0] q_addr;
   logic             q_pend;
   logic             busy;

   // Arbiter side
   modport slave (
      input  s0_valid, s0_tid, s0_reg, s0_be, s0_data,
      input  s1_valid, s1_tid, s1_reg, s1_be, s1_data,
      input  q_addr,
      output s0_ready, s1_ready,
      output wr, wa, wd,
      output q_pend, busy
   );

   // Producer / regfile / scoreboard side
   modport master (
      output s0_valid, s0_tid, s0_reg, s0_be, s0_data,
      output s1_valid, s1_tid, s1_reg, s1_be, s1_data,
      output q_addr,
      input  s0_ready, s1_ready,
      input  wr, wa, wd,
      input  q_pend, busy
   );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// GPR writeback arbiter: two private FIFOs (ALU/FPU results, load data) drained
// round-robin, one entry per cycle, onto a registered regfile write port.
// Also answers a combinational "write pending?" query for the issue scoreboard.
module gpr_wb_arbiter #(
   parameter int   TID_W     = 4,
   parameter int   DEPTH     = 4,
   parameter logic ZERO_PROT = 1'b1
) (
   input logic             clk,
   input logic             rst,
   gpr_wb_arbiter_if.slave bus
);
   localparam int AW     = $clog2(DEPTH);
   localparam int CW     = AW + 1;
   localparam int ADDR_W = TID_W + 6;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [3:0]        be;
      logic [31:0]       data;
   } entry_t;

   entry_t            mem_q    [2][DEPTH];
   entry_t            mem_d    [2][DEPTH];
   logic [AW-1:0]     wr_ptr_q [2];
   logic [AW-1:0]     wr_ptr_d [2];
   logic [AW-1:0]     rd_ptr_q [2];
   logic [AW-1:0]     rd_ptr_d [2];
   logic [CW-1:0]     count_q  [2];
   logic [CW-1:0]     count_d  [2];
   logic              rr_q, rr_d;
   logic [3:0]        wr_q, wr_d;
   logic [ADDR_W-1:0] wa_q, wa_d;
   logic [31:0]       wd_q, wd_d;

   entry_t            in_ent [2];
   logic [1:0]        in_valid;
   logic [1:0]        in_ready;
   logic [1:0]        push;
   logic [1:0]        pop;
   logic [1:0]        not_empty;
   logic              grant_vld;
   logic              grant_src;
   entry_t            head;
   logic              discard;
   logic [AW-1:0]     slot_ofs;
   logic              pend;

   // Source port unpacking and FIFO accept logic (no push-through when full)
   always_comb begin
      in_ent[0] = {bus.s0_tid, bus.s0_reg, bus.s0_be, bus.s0_data};
      in_ent[1] = {bus.s1_tid, bus.s1_reg, bus.s1_be, bus.s1_data};
      in_valid  = {bus.s1_valid, bus.s0_valid};
      for (int s = 0; s < 2; s++) begin
         not_empty[s] = (count_q[s] != CW'(0));
         in_ready[s]  = !rst && (count_q[s] != CW'(DEPTH));
         push[s]      = in_valid[s] && in_ready[s];
      end
   end

   // Round-robin grant; rr only advances when both sources contend
   always_comb begin
      grant_vld = 1'b0;
      grant_src = 1'b0;
      rr_d      = rr_q;
      pop       = 2'b00;
      if (not_empty[0] && not_empty[1]) begin
         grant_vld = 1'b1;
         grant_src = rr_q;
         rr_d      = ~rr_q;
      end else if (not_empty[0]) begin
         grant_vld = 1'b1;
         grant_src = 1'b0;
      end else if (not_empty[1]) begin
         grant_vld = 1'b1;
         grant_src = 1'b1;
      end else begin
         grant_vld = 1'b0;
         grant_src = 1'b0;
      end
      if (grant_vld) begin
         pop[grant_src] = 1'b1;
      end else begin
         pop = 2'b00;
      end
   end

   // Output register next-state; discarded entries are consumed but write nothing
   always_comb begin
      head    = mem_q[grant_src][rd_ptr_q[grant_src]];
      discard = (head.be == 4'b0000) || (ZERO_PROT && (head.addr[5:0] == 6'd0));
      wr_d    = 4'b0000;
      wa_d    = wa_q;
      wd_d    = wd_q;
      if (grant_vld) begin
         wr_d = discard ? 4'b0000 : head.be;
         wa_d = head.addr;
         wd_d = head.data;
      end else begin
         wr_d = 4'b0000;
      end
   end

   // FIFO storage, pointer and occupancy next-state for both sources
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         for (int j = 0; j < DEPTH; j++) begin
            mem_d[s][j] = mem_q[s][j];
         end
         wr_ptr_d[s] = wr_ptr_q[s];
         rd_ptr_d[s] = rd_ptr_q[s];
         count_d[s]  = count_q[s];
         if (push[s]) begin
            mem_d[s][wr_ptr_q[s]] = in_ent[s];
            wr_ptr_d[s]           = wr_ptr_q[s] + AW'(1);
         end else begin
            wr_ptr_d[s] = wr_ptr_q[s];
         end
         if (pop[s]) begin
            rd_ptr_d[s] = rd_ptr_q[s] + AW'(1);
         end else begin
            rd_ptr_d[s] = rd_ptr_q[s];
         end
         case ({push[s], pop[s]})
            2'b10:   count_d[s] = count_q[s] + CW'(1);
            2'b01:   count_d[s] = count_q[s] - CW'(1);
            default: count_d[s] = count_q[s];
         endcase
      end
   end

   // Pending-write lookup over every occupied slot (discards included) and the output reg
   always_comb begin
      pend     = 1'b0;
      slot_ofs = '0;
      for (int s = 0; s < 2; s++) begin
         for (int j = 0; j < DEPTH; j++) begin
            slot_ofs = AW'(j) - rd_ptr_q[s];
            if (({1'b0, slot_ofs} < count_q[s]) && (mem_q[s][j].addr == bus.q_addr)) begin
               pend = 1'b1;
            end else begin
               pend = pend;
            end
         end
      end
      if ((wr_q != 4'b0000) && (wa_q == bus.q_addr)) begin
         pend = 1'b1;
      end else begin
         pend = pend;
      end
      if (rst) begin
         pend = 1'b0;
      end else begin
         pend = pend;
      end
   end

   // Control and output registers with synchronous reset (queued writes are dropped)
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < 2; s++) begin
            wr_ptr_q[s] <= '0;
            rd_ptr_q[s] <= '0;
            count_q[s]  <= '0;
         end
         rr_q <= 1'b0;
         wr_q <= 4'b0000;
         wa_q <= '0;
         wd_q <= 32'h0000_0000;
      end else begin
         for (int s = 0; s < 2; s++) begin
            wr_ptr_q[s] <= wr_ptr_d[s];
            rd_ptr_q[s] <= rd_ptr_d[s];
            count_q[s]  <= count_d[s];
         end
         rr_q <= rr_d;
         wr_q <= wr_d;
         wa_q <= wa_d;
         wd_q <= wd_d;
      end
   end

   // FIFO payload storage; validity comes from the pointers, so no reset needed
   always_ff @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         for (int j = 0; j < DEPTH; j++) begin
            mem_q[s][j] <= mem_d[s][j];
         end
      end
   end

   assign bus.s0_ready = in_ready[0];
   assign bus.s1_ready = in_ready[1];
   assign bus.wr       = wr_q;
   assign bus.wa       = wa_q;
   assign bus.wd       = wd_q;
   assign bus.q_pend   = pend;
   assign bus.busy     = !rst && ((count_q[0] != CW'(0)) || (count_q[1] != CW'(0)) ||
                                  (wr_q != 4'b0000));
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed testbench for gpr_wb_arbiter. Inputs change and outputs are sampled
// on the falling edge; "cycle t" is the interval right after the t-th rising edge
// counted from the start of each step sequence.
module tb_gpr_wb_arbiter;
   localparam int TID_W = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_total = 0;
   int   n_pass  = 0;
   int   n_fail  = 0;

   // hand-derived output schedule for the contention/full sequence
   int   ord_src [13] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 1};
   int   ord_idx [13] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 6, 7};

   gpr_wb_arbiter_if #(.TID_W(TID_W)) bus ();

   gpr_wb_arbiter #(.TID_W(TID_W), .DEPTH(4), .ZERO_PROT(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive0(input logic v, input logic [3:0] tid, input logic [5:0] rg,
                         input logic [3:0] be, input logic [31:0] d);
      bus.s0_valid = v; bus.s0_tid = tid; bus.s0_reg = rg; bus.s0_be = be; bus.s0_data = d;
   endtask

   task automatic drive1(input logic v, input logic [3:0] tid, input logic [5:0] rg,
                         input logic [3:0] be, input logic [31:0] d);
      bus.s1_valid = v; bus.s1_tid = tid; bus.s1_reg = rg; bus.s1_be = be; bus.s1_data = d;
   endtask

   initial begin
      logic [9:0]  ea;
      logic [31:0] ed;
      rst = 1'b1;
      drive0(1'b0, 4'h0, 6'd0, 4'h0, 32'h0);
      drive1(1'b0, 4'h0, 6'd0, 4'h0, 32'h0);
      bus.q_addr = 10'h000;

      // ---- reset state ----
      tick(); tick();
      chk("rst s0_ready", bus.s0_ready, 1'b0);
      chk("rst s1_ready", bus.s1_ready, 1'b0);
      chk("rst busy", bus.busy, 1'b0);
      chk("rst q_pend", bus.q_pend, 1'b0);
      chk("rst wr", bus.wr, 4'h0);
      chk("rst wa", bus.wa, 10'h000);
      chk("rst wd", bus.wd, 32'h0);
      rst = 1'b0;
      #1;
      chk("post-rst s0_ready", bus.s0_ready, 1'b1);
      chk("post-rst s1_ready", bus.s1_ready, 1'b1);

      // ---- single write: tid=3 reg=5 -> wa = {4'h3, 6'd5} = 10'h0C5 ----
      tick();
      drive0(1'b1, 4'h3, 6'd5, 4'hF, 32'hDEAD_BEEF);
      tick();
      drive0(1'b0, 4'h0, 6'd0, 4'h0, 32'h0);
      chk("t1 c1 wr", bus.wr, 4'h0);
      chk("t1 c1 busy", bus.busy, 1'b1);
      tick();
      chk("t1 c2 wr", bus.wr, 4'hF);
      chk("t1 c2 wa", bus.wa, 10'h0C5);
      chk("t1 c2 wd", bus.wd, 32'hDEAD_BEEF);
      tick();
      chk("t1 c3 wr", bus.wr, 4'h0);
      chk("t1 c3 wa hold", bus.wa, 10'h0C5);
      chk("t1 c3 busy", bus.busy, 1'b0);

      // ---- contention: rr starts at src0, writes alternate s0,s1,... ----
      for (int t = 0; t <= 8; t++) begin
         if (t >= 2 && t <= 7) begin
            if (((t - 2) % 2) == 0) begin
               ea = {4'h2, 6'(10 + (t - 2) / 2)};
               ed = 32'hA000_0000 + 32'((t - 2) / 2);
            end else begin
               ea = {4'h5, 6'(20 + (t - 2) / 2)};
               ed = 32'hB000_0000 + 32'((t - 2) / 2);
            end
            chk($sformatf("t2 c%0d wr", t), bus.wr, 4'hF);
            chk($sformatf("t2 c%0d wa", t), bus.wa, ea);
            chk($sformatf("t2 c%0d wd", t), bus.wd, ed);
         end
         if (t == 7) chk("t2 c7 busy", bus.busy, 1'b1);
         if (t == 8) begin
            chk("t2 c8 wr", bus.wr, 4'h0);
            chk("t2 c8 busy", bus.busy, 1'b0);
         end
         if (t < 3) begin
            drive0(1'b1, 4'h2, 6'(10 + t), 4'hF, 32'hA000_0000 + 32'(t));
            drive1(1'b1, 4'h5, 6'(20 + t), 4'hF, 32'hB000_0000 + 32'(t));
         end else begin
            drive0(1'b0, 4'h0, 6'd0, 4'h0, 32'h0);
            drive1(1'b0, 4'h0, 6'd0, 4'h0, 32'h0);
         end
         tick();
      end

      // ---- full: s0 keeps contention up, s1 fills to 4; B7 held until a pop ----
      // rr points at src1 here (last contended grant went to src0).
      for (int t = 0; t <= 15; t++) begin
         chk($sformatf("t3 c%0d s1_ready", t), bus.s1_ready, (t == 7 || t == 9) ? 1'b0 : 1'b1);
         if (t >= 2 && t <= 14) begin
            if (ord_src[t - 2] == 0) begin
               ea = {4'h6, 6'(ord_idx[t - 2] + 1)};
               ed = 32'hA5A5_0000 + 32'(ord_idx[t - 2]);
            end else begin
               ea = {4'h9, 6'(ord_idx[t - 2] + 32)};
               ed = 32'h5A5A_0000 + 32'(ord_idx[t - 2]);
            end
            chk($sformatf("t3 c%0d wr", t), bus.wr, 4'hF);
            chk($sformatf("t3 c%0d wa", t), bus.wa, ea);
            chk($sformatf("t3 c%0d wd", t), bus.wd, ed);
         end else begin
            chk($sformatf("t3 c%0d wr idle", t), bus.wr, 4'h0);
         end
         if (t <= 4) drive0(1'b1, 4'h6, 6'(t + 1), 4'hF, 32'hA5A5_0000 + 32'(t));
         else        drive0(1'b0, 4'h0, 6'd0, 4'h0, 32'h0);
         if (t <= 6)                drive1(1'b1, 4'h9, 6'(t + 32), 4'hF, 32'h5A5A_0000 + 32'(t));
         else if (t == 7 || t == 8) drive1(1'b1, 4'h9, 6'(7 + 32), 4'hF, 32'h5A5A_0007);
         else                       drive1(1'b0, 4'h0, 6'd0, 4'h0, 32'h0);
         tick();
      end
      chk("t3 end busy", bus.busy, 1'b0);

      // ---- discard: reg 0, then be=0, then a real write ----
      for (int t = 0; t <= 5; t++) begin
         if (t == 2) begin
            chk("t4 c2 wr reg0", bus.wr, 4'h0);
            chk("t4 c2 busy", bus.busy, 1'b1);
         end
         if (t == 3) chk("t4 c3 wr be0", bus.wr, 4'h0);
         if (t == 4) begin
            chk("t4 c4 wr", bus.wr, 4'h3);
            chk("t4 c4 wa", bus.wa, 10'h087);
            chk("t4 c4 wd", bus.wd, 32'hAABB_CCDD);
         end
         if (t == 5) begin
            chk("t4 c5 wr", bus.wr, 4'h0);
            chk("t4 c5 busy", bus.busy, 1'b0);
         end
         case (t)
            0:       drive0(1'b1, 4'h2, 6'd0, 4'hF, 32'h0000_1234);
            1:       drive0(1'b1, 4'h2, 6'd7, 4'h0, 32'h5555_5555);
            2:       drive0(1'b1, 4'h2, 6'd7, 4'h3, 32'hAABB_CCDD);
            default: drive0(1'b0, 4'h0, 6'd0, 4'h0, 32'h0);
         endcase
         tick();
      end

      // ---- q_pend: X = {tid 1, reg 9} sits behind two src1 fillers (rr at src1) ----
      for (int t = 0; t <= 5; t++) begin
         bus.q_addr = 10'h049;
         #1;
         chk($sformatf("t5 c%0d pend 049", t), bus.q_pend, (t >= 2 && t <= 4) ? 1'b1 : 1'b0);
         bus.q_addr = 10'h04A;
         #1;
         chk($sformatf("t5 c%0d pend 04A", t), bus.q_pend, 1'b0);
         if (t == 4) begin
            chk("t5 c4 wr", bus.wr, 4'hF);
            chk("t5 c4 wa", bus.wa, 10'h049);
         end
         if (t == 0) drive1(1'b1, 4'h7, 6'd3, 4'hF, 32'h1111_0000);
         else if (t == 1) drive1(1'b1, 4'h7, 6'd4, 4'hF, 32'h1111_0001);
         else drive1(1'b0, 4'h0, 6'd0, 4'h0, 32'h0);
         if (t == 1) drive0(1'b1, 4'h1, 6'd9, 4'hF, 32'h0909_0909);
         else        drive0(1'b0, 4'h0, 6'd0, 4'h0, 32'h0);
         tick();
      end

      // ---- reset mid-operation ----
      for (int t = 0; t <= 5; t++) begin
         drive0(1'b1, 4'h3, 6'd3, 4'hF, 32'hCCCC_0000 + 32'(t));
         drive1(1'b1, 4'h3, 6'd4, 4'hF, 32'hDDDD_0000 + 32'(t));
         tick();
      end
      drive0(1'b0, 4'h0, 6'd0, 4'h0, 32'h0);
      drive1(1'b0, 4'h0, 6'd0, 4'h0, 32'h0);
      bus.q_addr = 10'h0C3;
      #1;
      chk("t6 pre busy", bus.busy, 1'b1);
      chk("t6 pre q_pend", bus.q_pend, 1'b1);
      rst = 1'b1;
      #1;
      chk("t6 in-rst s0_ready", bus.s0_ready, 1'b0);
      chk("t6 in-rst s1_ready", bus.s1_ready, 1'b0);
      chk("t6 in-rst busy", bus.busy, 1'b0);
      chk("t6 in-rst q_pend", bus.q_pend, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      chk("t6 after wr", bus.wr, 4'h0);
      chk("t6 after busy", bus.busy, 1'b0);
      chk("t6 after s0_ready", bus.s0_ready, 1'b1);
      chk("t6 after s1_ready", bus.s1_ready, 1'b1);
      chk("t6 after q_pend", bus.q_pend, 1'b0);
      for (int t = 1; t <= 4; t++) begin
         tick();
         chk($sformatf("t6 c%0d no stale wr", t), bus.wr, 4'h0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
